mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store front-end between the core's MEM stage and block_ram (single-port, word-wide, 1-cycle registered read).
//  Accepts one RISC-V style load/store per handshake, converts byte address to word index, performs sub-word
//  store as read-modify-write, aligns and sign/zero-extends load data, flags misaligned/out-of-range/illegal ops.
// PARAMETERS
//  MEM_WORDS  1024  words in attached block_ram; valid word index 0..MEM_WORDS-1
//  BASE_ADDR  0     byte address mapped to word index 0
// PORTS
//  clk         in   1   single clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (IDLE only); transfer when req_valid&&req_ready at rising edge
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   load: 000 LB,001 LH,010 LW,100 LBU,101 LHU; store: 000 SB,001 SH,010 SW
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte/half used for SB/SH)
//  resp_valid  out  1   one-cycle response pulse; core always accepts (no back-pressure)
//  resp_rdata  out  32  load result; 0 for stores and errors
//  resp_err    out  1   misaligned, out-of-range or illegal funct3; valid with resp_valid
//  mem_we      out  1   block_ram write enable
//  mem_addr    out  32  block_ram word index = (req_addr-BASE_ADDR)>>2, zero-extended
//  mem_di      out  32  block_ram write data
//  mem_dout    in   32  block_ram read data, valid the cycle after mem_addr is presented with mem_we=0
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_di=0, req_ready=0 while rst high.
//  mem_we/mem_addr/mem_di decoded combinationally from state + captured request regs; mem_we gated by ~rst.
//  Outside ISSUE/WAIT/MERGE: mem_we=0, mem_addr=0, mem_di=0. resp_* registered; resp_valid=1 only in RESP.
//  Acceptance edge captures we/funct3/addr/wdata; no new request until back in IDLE.
//  States / transitions (N = cycles after acceptance edge that resp_valid is high):
//   IDLE  -> RESP   error detected at accept: resp_err=1, no memory access (N=1)
//   IDLE  -> ISSUE  otherwise
//   ISSUE: mem_addr=word idx; SW: mem_we=1, mem_di=wdata -> RESP (N=2); loads/SB/SH: mem_we=0 -> WAIT
//   WAIT : mem_dout valid; load: resp_rdata<=extended lane -> RESP (N=3); SB/SH: merge reg<=mem_dout with lane replaced -> MERGE
//   MERGE: mem_we=1, mem_addr=word idx, mem_di=merge reg -> RESP (N=4)
//   RESP : resp_valid=1 one cycle -> IDLE (req_ready=1 next cycle)
//  Errors: LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0; addr<BASE_ADDR or word idx>=MEM_WORDS;
//   funct3 011/110/111 (loads) or any funct3 other than 000/001/010 (stores). Error never drives mem_we.
//  Lanes little-endian: byte off=addr[1:0] -> bits[8*off+7:8*off]; half off=addr[1] -> bits[16*off+15:16*off].
//  LB/LH sign-extend to 32b; LBU/LHU zero-extend. Word-index subtraction in 32b, no wrap: addr<BASE_ADDR is error.
//  Reset mid-operation: rst high in any state forces mem_we=0 that cycle (no partial RMW write); IDLE next cycle,
//   pending request dropped, no response issued.
//  req_valid deasserted while busy is ignored; fields may change while busy (captured copy used).
// TESTING (block_ram model attached, MEM_WORDS=1024, BASE_ADDR=0)
//  1 SW 0x100 wdata 0xDEADBEEF -> one mem_we pulse, mem_addr 0x40, mem_di 0xDEADBEEF; resp_valid N=2, err 0
//  2 after 1: LW 0x100 -> 0xDEADBEEF N=3; LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF
//  3 SB 0x101 wdata 0x12345655 -> read, then mem_di 0xDEAD55EF, N=4; SH 0x102 wdata 0x0000CAFE; LW 0x100 -> 0xCAFE55EF
//  4 LW 0x102, SH 0x101, LW 0x1000, load funct3 011 -> resp_err=1 N=1, resp_rdata 0, mem_we never high, mem_addr stays 0
//  5 req_valid held high over 3 queued requests -> req_ready low ISSUE..RESP, each accepted one cycle after prior RESP
//  6 rst high during MERGE of SB 0x100 -> mem_we 0 that cycle, word 0x40 unchanged, no resp, reset values next cycle

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end between the MEM stage and a single-port, 1-cycle-read block RAM.
// Sub-word stores are done as read-modify-write; loads are lane-aligned and sign/zero-extended.
//
// state | meaning
// IDLE  | ready for a request; errors are answered straight from here
// ISSUE | word index on the RAM; SW writes here, everything else reads
// WAIT  | RAM read data valid; loads build the result, SB/SH build the merged word
// MERGE | merged word written back for SB/SH
// RESP  | one-cycle response pulse

module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_MERGE,
      S_RESP
   } state_t;

   localparam logic [2:0]  F3_B  = 3'b000;
   localparam logic [2:0]  F3_H  = 3'b001;
   localparam logic [2:0]  F3_W  = 3'b010;
   localparam logic [2:0]  F3_BU = 3'b100;
   localparam logic [2:0]  F3_HU = 3'b101;
   // byte-offset limit kept in 34 bits so large MEM_WORDS cannot overflow the compare
   localparam logic [33:0] LIMIT_BYTES = 34'(MEM_WORDS) << 2;

   state_t      state, state_next;

   logic        cap_we;
   logic [2:0]  cap_f3;
   logic [1:0]  cap_lane;
   logic [31:0] cap_idx;
   logic [31:0] cap_wdata;
   logic [31:0] merge_q;

   logic        accept;
   logic        funct3_bad;
   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [31:0] req_off;

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] merged;
   logic [31:0] resp_rdata_next;
   logic        resp_err_next;

   assign req_ready = (state == S_IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   always_comb begin
      funct3_bad = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         funct3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         funct3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign req_off      = req_addr - BASE_ADDR;
   assign out_of_range = (req_addr < BASE_ADDR) || ({2'b00, req_off} >= LIMIT_BYTES);
   assign req_err      = funct3_bad || misaligned || out_of_range;

   always_comb begin
      lane_b = 8'h00;
      case (cap_lane)
         2'd0: lane_b = mem_dout[7:0];
         2'd1: lane_b = mem_dout[15:8];
         2'd2: lane_b = mem_dout[23:16];
         2'd3: lane_b = mem_dout[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = cap_lane[1] ? mem_dout[31:16] : mem_dout[15:0];

      load_val = 32'h0;
      case (cap_f3)
         F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
         F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
         F3_W:    load_val = mem_dout;
         F3_BU:   load_val = {24'h0, lane_b};
         F3_HU:   load_val = {16'h0, lane_h};
         default: load_val = 32'h0;
      endcase

      merged = mem_dout;
      if (cap_f3 == F3_B) begin
         case (cap_lane)
            2'd0: merged[7:0]   = cap_wdata[7:0];
            2'd1: merged[15:8]  = cap_wdata[7:0];
            2'd2: merged[23:16] = cap_wdata[7:0];
            2'd3: merged[31:24] = cap_wdata[7:0];
            default: merged = mem_dout;
         endcase
      end else if (cap_f3 == F3_H) begin
         if (cap_lane[1]) begin
            merged[31:16] = cap_wdata[15:0];
         end else begin
            merged[15:0] = cap_wdata[15:0];
         end
      end
   end

   always_comb begin
      state_next      = state;
      resp_rdata_next = 32'h0;
      resp_err_next   = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = 32'h0;
      mem_di          = 32'h0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next    = req_err ? S_RESP : S_ISSUE;
               resp_err_next = req_err;
            end
         end
         S_ISSUE: begin
            mem_addr = cap_idx;
            if (cap_we && (cap_f3 == F3_W)) begin
               mem_we     = 1'b1;
               mem_di     = cap_wdata;
               state_next = S_RESP;
            end else begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_addr = cap_idx;
            if (cap_we) begin
               state_next = S_MERGE;
            end else begin
               resp_rdata_next = load_val;
               state_next      = S_RESP;
            end
         end
         S_MERGE: begin
            mem_we     = 1'b1;
            mem_addr   = cap_idx;
            mem_di     = merge_q;
            state_next = S_RESP;
         end
         S_RESP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      // reset wins immediately so an in-flight RMW never completes a partial write
      if (rst) begin
         mem_we   = 1'b0;
         mem_addr = 32'h0;
         mem_di   = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         cap_we     <= 1'b0;
         cap_f3     <= 3'b000;
         cap_lane   <= 2'b00;
         cap_idx    <= 32'h0;
         cap_wdata  <= 32'h0;
         merge_q    <= 32'h0;
      end else begin
         state      <= state_next;
         resp_valid <= (state_next == S_RESP);
         resp_rdata <= resp_rdata_next;
         resp_err   <= resp_err_next;
         if (accept) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_lane  <= req_addr[1:0];
            cap_idx   <= {2'b00, req_off[31:2]};
            cap_wdata <= req_wdata;
         end
         if (state == S_WAIT) begin
            merge_q <= merged;
         end
      end
   end

endmodule
